// File: rtl/rr_iter_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : rr_iter_sequencer
// Brief   : Multi-pass sequencer around an external rotate-right unit.
//           Each pass applies at most STEP_MAX positions.
// Revision: 1.0
// ============================================================================
module rr_iter_sequencer #(
   parameter int WIDTH    = 4,
   parameter int AMT_W    = 4,
   parameter int STEP_MAX = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [AMT_W-1:0] in_amt,
   output logic [WIDTH-1:0] rot_a,
   output logic [WIDTH-1:0] rot_b,
   input  logic [WIDTH-1:0] rot_r,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_r,
   output logic [AMT_W-1:0] out_passes
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [AMT_W-1:0] c_step_max = AMT_W'(STEP_MAX);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_out_r;
   logic [AMT_W-1:0] r_rem;
   logic [AMT_W-1:0] r_passes;
   logic [AMT_W-1:0] r_out_passes;
   logic [AMT_W-1:0] w_step;
   logic [AMT_W-1:0] w_rem_nxt;
   logic             w_last_pass;

   assign w_step      = (r_rem > c_step_max) ? c_step_max : r_rem;
   assign w_rem_nxt   = r_rem - w_step;
   assign w_last_pass = (w_rem_nxt == '0);

   assign out_r      = r_out_r;
   assign out_passes = r_out_passes;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // rot_a/rot_b come straight from registered state, so the unit sees a
   // clean zero-amount pass-through whenever no pass is in flight.
   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      rot_a       = r_acc;
      rot_b       = '0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_state_nxt = (in_amt != '0) ? S_RUN : S_DONE;
            end
         end
         S_RUN: begin
            rot_b = WIDTH'(w_step);
            if (w_last_pass) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc        <= '0;
         r_rem        <= '0;
         r_passes     <= '0;
         r_out_r      <= '0;
         r_out_passes <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_acc    <= in_a;
                  r_rem    <= in_amt;
                  r_passes <= '0;
                  if (in_amt == '0) begin
                     r_out_r      <= in_a;
                     r_out_passes <= '0;
                  end
               end
            end
            S_RUN: begin
               r_acc    <= rot_r;
               r_rem    <= w_rem_nxt;
               r_passes <= r_passes + AMT_W'(1);
               if (w_last_pass) begin
                  r_out_r      <= rot_r;
                  r_out_passes <= r_passes + AMT_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rr_iter_sequencer.sv
`default_nettype none
// Directed bench for rr_iter_sequencer; the rotate unit is modelled inline.
module tb_rr_iter_sequencer;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_a;
   logic [3:0] in_amt;
   logic [3:0] rot_a;
   logic [3:0] rot_b;
   logic [3:0] rot_r;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_r;
   logic [3:0] out_passes;

   int total;
   int bad;

   function automatic logic [3:0] rotr(input logic [3:0] a, input int n);
      logic [7:0] t;
      t = {a, a} >> (n % 4);
      return t[3:0];
   endfunction

   assign rot_r = rotr(rot_a, int'(rot_b));

   rr_iter_sequencer #(.WIDTH(4), .AMT_W(4), .STEP_MAX(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_amt    (in_amt),
      .rot_a     (rot_a),
      .rot_b     (rot_b),
      .rot_r     (rot_r),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_r     (out_r),
      .out_passes(out_passes)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] va [5];
      logic [3:0] vm [5];
      logic [3:0] exp_acc;
      int cnt;
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      in_a = 4'h0;
      in_amt = 4'h0;
      #12;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_r", 32'(out_r), 32'd0);
      chk("rst_out_passes", 32'(out_passes), 32'd0);
      chk("rst_rot_a", 32'(rot_a), 32'd0);
      chk("rst_rot_b", 32'(rot_b), 32'd0);
      rst_n = 1'b1;
      step();
      chk("idle_in_ready", 32'(in_ready), 32'd1);

      // case 1 + backpressure (case 4)
      in_a = 4'b1011; in_amt = 4'd5; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk("c1_run_in_ready", 32'(in_ready), 32'd0);
      chk("c1_p1_rot_a", 32'(rot_a), 32'b1011);
      chk("c1_p1_rot_b", 32'(rot_b), 32'd3);
      step();
      chk("c1_p2_rot_a", 32'(rot_a), 32'b0111);
      chk("c1_p2_rot_b", 32'(rot_b), 32'd2);
      chk("c1_p2_out_valid", 32'(out_valid), 32'd0);
      step();
      in_a = 4'b1010; in_amt = 4'd0; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("c4_out_valid", 32'(out_valid), 32'd1);
         chk("c4_out_r", 32'(out_r), 32'b1101);
         chk("c4_out_passes", 32'(out_passes), 32'd2);
         chk("c4_in_ready", 32'(in_ready), 32'd0);
         chk("c4_rot_b", 32'(rot_b), 32'd0);
         step();
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("c4_back_idle_valid", 32'(out_valid), 32'd0);
      chk("c4_back_idle_ready", 32'(in_ready), 32'd1);

      // case 3: zero amount accepted from the held request
      step();
      in_valid = 1'b0;
      chk("c3_out_valid", 32'(out_valid), 32'd1);
      chk("c3_out_r", 32'(out_r), 32'b1010);
      chk("c3_out_passes", 32'(out_passes), 32'd0);
      chk("c3_rot_b", 32'(rot_b), 32'd0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("c3_idle", 32'(in_ready), 32'd1);

      // case 2: 15 positions, five passes of 3
      in_a = 4'b0001; in_amt = 4'd15; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      exp_acc = 4'b0001;
      for (int p = 0; p < 5; p++) begin
         chk("c2_rot_b", 32'(rot_b), 32'd3);
         chk("c2_rot_a", 32'(rot_a), 32'(exp_acc));
         chk("c2_busy_valid", 32'(out_valid), 32'd0);
         exp_acc = rotr(exp_acc, 3);
         step();
      end
      chk("c2_out_valid", 32'(out_valid), 32'd1);
      chk("c2_out_r", 32'(out_r), 32'b0010);
      chk("c2_out_passes", 32'(out_passes), 32'd5);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

      // case 5: reset after two passes of case 2
      in_a = 4'b0001; in_amt = 4'd15; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      chk("c5_mid_rot_b", 32'(rot_b), 32'd3);
      #2 rst_n = 1'b0;
      #1;
      chk("c5_rst_out_valid", 32'(out_valid), 32'd0);
      chk("c5_rst_out_r", 32'(out_r), 32'd0);
      chk("c5_rst_rot_a", 32'(rot_a), 32'd0);
      #3 rst_n = 1'b1;
      step();
      chk("c5_release_ready", 32'(in_ready), 32'd1);
      in_a = 4'b1011; in_amt = 4'd5; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      cnt = 0;
      while (!out_valid && cnt < 20) begin
         step();
         cnt++;
      end
      chk("c5_latency", 32'(cnt), 32'd2);
      chk("c5_out_r", 32'(out_r), 32'b1101);
      chk("c5_out_passes", 32'(out_passes), 32'd2);
      out_ready = 1'b1;
      step();

      // case 6: back-to-back with in_valid held and out_ready high
      va[0] = 4'b1100; vm[0] = 4'd7;
      va[1] = 4'b0110; vm[1] = 4'd3;
      va[2] = 4'b1001; vm[2] = 4'd0;
      va[3] = 4'b0011; vm[3] = 4'd14;
      va[4] = 4'b1110; vm[4] = 4'd1;
      in_valid = 1'b1;
      for (int j = 0; j < 5; j++) begin
         in_a = va[j]; in_amt = vm[j];
         chk("c6_accept_ready", 32'(in_ready), 32'd1);
         step();
         cnt = 0;
         while (!out_valid && cnt < 20) begin
            chk("c6_busy_ready", 32'(in_ready), 32'd0);
            step();
            cnt++;
         end
         chk("c6_latency", 32'(cnt), 32'((int'(vm[j]) + 2) / 3));
         chk("c6_out_r", 32'(out_r), 32'(rotr(va[j], int'(vm[j]))));
         chk("c6_out_passes", 32'(out_passes), 32'((int'(vm[j]) + 2) / 3));
         chk("c6_done_ready", 32'(in_ready), 32'd0);
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
